// File: rtl/html_block_renderer_pkg.sv
// Shared widths, opcodes, screen defaults and FSM encoding for the html block renderer.
// Width constants must stay in step with the parser and the framebuffer adapter.
package html_block_renderer_pkg;

  localparam int unsigned X_BITES             = 8;
  localparam int unsigned Y_BITES             = 7;
  localparam int unsigned COLOR_BITES         = 3;
  localparam int unsigned ATTRIBUTE_VAL_BITES = 8;

  localparam int unsigned SCREEN_W_DEFAULT = 160;
  localparam int unsigned SCREEN_H_DEFAULT = 120;

  localparam logic OP_FILL_RECT = 1'b0;
  localparam logic OP_CLEAR     = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CLIP = 2'd1,
    ST_DRAW = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/html_block_renderer.sv
// Turns FILL_RECT / CLEAR block commands into a clipped, row-major stream of pixel writes.
// One command in flight at a time; the clip bounds are computed in a single CLIP cycle.
module html_block_renderer
  import html_block_renderer_pkg::*;
#(
  parameter int unsigned SCREEN_W = SCREEN_W_DEFAULT,
  parameter int unsigned SCREEN_H = SCREEN_H_DEFAULT,
  parameter int unsigned X_W      = X_BITES,
  parameter int unsigned Y_W      = Y_BITES,
  parameter int unsigned COLOR_W  = COLOR_BITES
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_op,
  input  logic [X_W-1:0]     cmd_x,
  input  logic [Y_W-1:0]     cmd_y,
  input  logic [X_W-1:0]     cmd_w,
  input  logic [Y_W-1:0]     cmd_h,
  input  logic [COLOR_W-1:0] cmd_color,
  output logic               plot_valid,
  input  logic               plot_ready,
  output logic [X_W-1:0]     plot_x,
  output logic [Y_W-1:0]     plot_y,
  output logic [COLOR_W-1:0] plot_color,
  output logic               busy,
  output logic               done
);

  localparam logic [X_W:0] XLim = SCREEN_W[X_W:0];
  localparam logic [Y_W:0] YLim = SCREEN_H[Y_W:0];

  state_e             state_q, state_d;
  logic               op_q, op_d;
  logic [X_W-1:0]     x_q, x_d, w_q, w_d, curX_q, curX_d;
  logic [Y_W-1:0]     y_q, y_d, h_q, h_d, curY_q, curY_d;
  logic [X_W:0]       xEnd_q, xEnd_d;
  logic [Y_W:0]       yEnd_q, yEnd_d;
  logic [COLOR_W-1:0] color_q, color_d;

  logic [X_W:0] xSum, xEndClip, curXInc;
  logic [Y_W:0] ySum, yEndClip, curYInc;
  logic         reject;

  // One extra bit on every sum so x+w and cur+1 can never wrap past the screen edge.
  assign xSum     = {1'b0, x_q} + {1'b0, w_q};
  assign ySum     = {1'b0, y_q} + {1'b0, h_q};
  assign xEndClip = (xSum > XLim) ? XLim : xSum;
  assign yEndClip = (ySum > YLim) ? YLim : ySum;
  assign curXInc  = {1'b0, curX_q} + (X_W+1)'(1);
  assign curYInc  = {1'b0, curY_q} + (Y_W+1)'(1);
  assign reject   = (op_q == OP_FILL_RECT) &&
                    ((w_q == '0) || (h_q == '0) ||
                     ({1'b0, x_q} >= XLim) || ({1'b0, y_q} >= YLim));

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      op_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      w_q     <= '0;
      h_q     <= '0;
      color_q <= '0;
      xEnd_q  <= '0;
      yEnd_q  <= '0;
      curX_q  <= '0;
      curY_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      x_q     <= x_d;
      y_q     <= y_d;
      w_q     <= w_d;
      h_q     <= h_d;
      color_q <= color_d;
      xEnd_q  <= xEnd_d;
      yEnd_q  <= yEnd_d;
      curX_q  <= curX_d;
      curY_q  <= curY_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    x_d     = x_q;
    y_d     = y_q;
    w_d     = w_q;
    h_d     = h_q;
    color_d = color_q;
    xEnd_d  = xEnd_q;
    yEnd_d  = yEnd_q;
    curX_d  = curX_q;
    curY_d  = curY_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          op_d    = cmd_op;
          x_d     = cmd_x;
          y_d     = cmd_y;
          w_d     = cmd_w;
          h_d     = cmd_h;
          color_d = cmd_color;
          state_d = ST_CLIP;
        end
      end
      ST_CLIP: begin
        if (reject) begin
          state_d = ST_DONE;
        end else if (op_q == OP_CLEAR) begin
          x_d     = '0;
          y_d     = '0;
          xEnd_d  = XLim;
          yEnd_d  = YLim;
          curX_d  = '0;
          curY_d  = '0;
          state_d = ST_DRAW;
        end else begin
          xEnd_d  = xEndClip;
          yEnd_d  = yEndClip;
          curX_d  = x_q;
          curY_d  = y_q;
          state_d = ST_DRAW;
        end
      end
      // x_q/y_q hold the clipped rectangle origin, used to restart each row.
      ST_DRAW: begin
        if (plot_ready) begin
          if (curXInc < xEnd_q) begin
            curX_d = curXInc[X_W-1:0];
          end else if (curYInc < yEnd_q) begin
            curX_d = x_q;
            curY_d = curYInc[Y_W-1:0];
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are qualified with resetn so everything reads zero while reset is held.
  assign cmd_ready  = resetn && (state_q == ST_IDLE);
  assign busy       = resetn && ((state_q == ST_CLIP) || (state_q == ST_DRAW));
  assign plot_valid = resetn && (state_q == ST_DRAW);
  assign done       = resetn && (state_q == ST_DONE);
  assign plot_x     = plot_valid ? curX_q  : '0;
  assign plot_y     = plot_valid ? curY_q  : '0;
  assign plot_color = plot_valid ? color_q : '0;

endmodule

// File: tb/tb_html_block_renderer.sv
// Randomised bench for html_block_renderer; expected pixel streams come from a
// rectangle-intersection model built with plain loops over the clipped area.
module tb_html_block_renderer;

  localparam int SW = 160;
  localparam int SH = 120;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_op = 1'b0;
  logic [7:0] cmd_x = '0;
  logic [6:0] cmd_y = '0;
  logic [7:0] cmd_w = '0;
  logic [6:0] cmd_h = '0;
  logic [2:0] cmd_color = '0;
  logic       plot_valid;
  logic       plot_ready = 1'b1;
  logic [7:0] plot_x;
  logic [6:0] plot_y;
  logic [2:0] plot_color;
  logic       busy;
  logic       done;

  int total = 0;
  int bad = 0;
  int cycle = 0;
  int expQ[$];
  int gotQ[$];
  int hsCyc, doneCyc, plotCycles, readyViol, stallViol, busyViol;
  bit timedOut;

  html_block_renderer dut (
    .clock(clock), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_color(cmd_color),
    .plot_valid(plot_valid), .plot_ready(plot_ready),
    .plot_x(plot_x), .plot_y(plot_y), .plot_color(plot_color),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cycle <= cycle + 1;

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached (actual=running required=finished)");
    $fatal(1, "[TB] watchdog");
  end

  function automatic int pack(int x, int y, int c);
    return (c << 16) | (x << 8) | y;
  endfunction

  // Expected stream = every point of the command rectangle intersected with the screen.
  function automatic void buildExpected(bit op, int x, int y, int w, int h, int c);
    int x0, y0, x1, y1;
    expQ.delete();
    if (op) begin
      x0 = 0; y0 = 0; x1 = SW; y1 = SH;
    end else begin
      x0 = x; y0 = y;
      x1 = (x + w > SW) ? SW : x + w;
      y1 = (y + h > SH) ? SH : y + h;
    end
    for (int yy = y0; yy < y1; yy++)
      for (int xx = x0; xx < x1; xx++)
        expQ.push_back(pack(xx, yy, c));
  endfunction

  function automatic int firstDiff();
    int n;
    n = (gotQ.size() < expQ.size()) ? gotQ.size() : expQ.size();
    for (int i = 0; i < n; i++)
      if (gotQ[i] != expQ[i]) return i;
    if (gotQ.size() != expQ.size()) return n;
    return -1;
  endfunction

  task automatic issue(bit op, int x, int y, int w, int h, int c);
    bit got;
    got = 0;
    @(negedge clock);
    cmd_op = op; cmd_x = 8'(x); cmd_y = 7'(y); cmd_w = 8'(w); cmd_h = 7'(h);
    cmd_color = 3'(c); cmd_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (cmd_ready) begin
        got = 1;
        break;
      end
      @(negedge clock);
    end
    hsCyc = cycle;
    total++;
    if (!got) begin
      bad++;
      $display("[TB] FAIL issue_accept: cmd_ready actual=0 required=1 within 50 cycles");
    end
  endtask

  // Runs one command to completion, scrambling cmd_* so only latched values can matter.
  task automatic collect(bit randReady, int budget);
    bit stalled;
    int sx, sy, sc;
    stalled = 0; sx = 0; sy = 0; sc = 0;
    gotQ.delete();
    readyViol = 0; stallViol = 0; busyViol = 0; plotCycles = 0;
    doneCyc = -1; timedOut = 1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      cmd_valid = 1'b0;
      cmd_op = 1'($urandom); cmd_x = 8'($urandom); cmd_y = 7'($urandom);
      cmd_w = 8'($urandom); cmd_h = 7'($urandom); cmd_color = 3'($urandom);
      plot_ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
      if (cmd_ready) readyViol++;
      if (stalled && (!plot_valid || plot_x != sx || plot_y != sy || plot_color != sc))
        stallViol++;
      stalled = 0;
      if (plot_valid) begin
        plotCycles++;
        if (plot_ready) gotQ.push_back(pack(plot_x, plot_y, plot_color));
        else begin
          stalled = 1; sx = plot_x; sy = plot_y; sc = plot_color;
        end
      end
      if (done) begin
        doneCyc = cycle;
        timedOut = 0;
        if (busy) busyViol++;
        break;
      end else if (!busy) begin
        busyViol++;
      end
    end
    plot_ready = 1'b1;
    if (timedOut) begin
      total++; bad++;
      $display("[TB] FAIL collect_timeout: done actual=none required=pulse within %0d cycles", budget);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; cmd_valid = 1'b0; plot_ready = 1'b1;
    repeat (3) @(negedge clock);
    total++;
    if ({cmd_ready, plot_valid, busy, done, plot_x, plot_y, plot_color} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_outputs: actual rdy=%b pv=%b busy=%b done=%b x=%0d y=%0d c=%0d required all 0",
               cmd_ready, plot_valid, busy, done, plot_x, plot_y, plot_color);
    end
    resetn = 1'b1;
    @(negedge clock);
    total++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_release: cmd_ready=%b busy=%b required 1/0", cmd_ready, busy);
    end
  endtask

  task automatic test_fill_basic();
    issue(0, 10, 5, 3, 2, 4);
    collect(0, 200);
    buildExpected(0, 10, 5, 3, 2, 4);
    total++;
    if (firstDiff() !== -1) begin
      bad++;
      $display("[TB] FAIL fill_stream: diverges at %0d actual size=%0d required size=%0d", firstDiff(), gotQ.size(), expQ.size());
    end
    total++;
    if (doneCyc !== hsCyc + 8) begin
      bad++;
      $display("[TB] FAIL fill_done_latency: actual=%0d required=%0d", doneCyc - hsCyc, 8);
    end
    total++;
    if (plotCycles !== 6 || readyViol !== 0 || busyViol !== 0) begin
      bad++;
      $display("[TB] FAIL fill_handshake: plotCycles=%0d readyViol=%0d busyViol=%0d required 6/0/0", plotCycles, readyViol, busyViol);
    end
  endtask

  task automatic test_clip_corner();
    int c;
    c = $urandom_range(0, 7);
    issue(0, 158, 118, 10, 10, c);
    collect(0, 200);
    buildExpected(0, 158, 118, 10, 10, c);
    total++;
    if (firstDiff() !== -1 || gotQ.size() !== 4) begin
      bad++;
      $display("[TB] FAIL clip_stream: diverges at %0d actual size=%0d required size=4", firstDiff(), gotQ.size());
    end
    total++;
    if (doneCyc !== hsCyc + 6) begin
      bad++;
      $display("[TB] FAIL clip_done_latency: actual=%0d required=6", doneCyc - hsCyc);
    end
  endtask

  task automatic test_reject();
    int xs[2] = '{30, 200};
    int ws[2] = '{0, 5};
    for (int k = 0; k < 2; k++) begin
      issue(0, xs[k], 10, ws[k], 3, 5);
      collect(0, 50);
      total++;
      if (plotCycles !== 0 || doneCyc !== hsCyc + 2) begin
        bad++;
        $display("[TB] FAIL reject_%0d: plots=%0d latency=%0d required plots=0 latency=2", k, plotCycles, doneCyc - hsCyc);
      end
      @(negedge clock);
      total++;
      if (cmd_ready !== 1'b1) begin
        bad++;
        $display("[TB] FAIL reject_ready_%0d: cmd_ready actual=%b required=1", k, cmd_ready);
      end
    end
  endtask

  task automatic test_clear_stall();
    issue(1, $urandom_range(0, 255), $urandom_range(0, 127), 0, 0, 7);
    collect(1, 60000);
    buildExpected(1, 0, 0, 0, 0, 7);
    total++;
    if (firstDiff() !== -1) begin
      bad++;
      $display("[TB] FAIL clear_stream: diverges at %0d actual size=%0d required size=%0d", firstDiff(), gotQ.size(), expQ.size());
    end
    total++;
    if (stallViol !== 0 || readyViol !== 0 || busyViol !== 0) begin
      bad++;
      $display("[TB] FAIL clear_stall: stallViol=%0d readyViol=%0d busyViol=%0d required 0/0/0", stallViol, readyViol, busyViol);
    end
  endtask

  task automatic test_reset_mid();
    int seen, extraPlots, extraDone;
    bit rdy;
    seen = 0; extraPlots = 0; extraDone = 0;
    issue(0, 20, 30, 4, 4, 2);
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      cmd_valid = 1'b0; plot_ready = 1'b1;
      if (plot_valid) seen++;
      if (seen == 5) break;
    end
    total++;
    if (seen !== 5) begin
      bad++;
      $display("[TB] FAIL midreset_prefix: plots actual=%0d required=5", seen);
    end
    @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    total++;
    if ({cmd_ready, plot_valid, busy, done, plot_x, plot_y, plot_color} !== '0) begin
      bad++;
      $display("[TB] FAIL midreset_outputs: rdy=%b pv=%b busy=%b done=%b required all 0", cmd_ready, plot_valid, busy, done);
    end
    resetn = 1'b1;
    @(negedge clock);
    rdy = cmd_ready;
    for (int i = 0; i < 10; i++) begin
      if (plot_valid) extraPlots++;
      if (done) extraDone++;
      @(negedge clock);
    end
    total++;
    if (rdy !== 1'b1 || extraPlots !== 0 || extraDone !== 0) begin
      bad++;
      $display("[TB] FAIL midreset_after: rdy=%b plots=%0d dones=%0d required 1/0/0", rdy, extraPlots, extraDone);
    end
    issue(0, 77, 66, 1, 1, 3);
    collect(0, 50);
    buildExpected(0, 77, 66, 1, 1, 3);
    total++;
    if (firstDiff() !== -1 || doneCyc !== hsCyc + 3) begin
      bad++;
      $display("[TB] FAIL midreset_single: size=%0d latency=%0d required size=1 latency=3", gotQ.size(), doneCyc - hsCyc);
    end
  endtask

  task automatic test_random();
    int x, y, w, h, c;
    for (int k = 0; k < 8; k++) begin
      x = $urandom_range(0, 170); y = $urandom_range(0, 127);
      w = $urandom_range(0, 24);  h = $urandom_range(0, 12);
      c = $urandom_range(0, 7);
      issue(0, x, y, w, h, c);
      collect(1, 3000);
      buildExpected(0, x, y, w, h, c);
      total++;
      if (firstDiff() !== -1) begin
        bad++;
        $display("[TB] FAIL random_%0d stream (x=%0d y=%0d w=%0d h=%0d): diverges at %0d actual size=%0d required size=%0d",
                 k, x, y, w, h, firstDiff(), gotQ.size(), expQ.size());
      end
      total++;
      if (stallViol !== 0 || readyViol !== 0 || busyViol !== 0 || doneCyc < hsCyc + 2 + expQ.size()) begin
        bad++;
        $display("[TB] FAIL random_%0d protocol: stall=%0d ready=%0d busy=%0d latency=%0d required 0/0/0 latency>=%0d",
                 k, stallViol, readyViol, busyViol, doneCyc - hsCyc, 2 + expQ.size());
      end
    end
  endtask

  task automatic test_back_to_back();
    int combined[$];
    int hs1, hs2, done1, done2, accepts;
    hs2 = -1; done1 = -1; done2 = -1; accepts = 0;
    buildExpected(0, 3, 4, 2, 2, 1);
    combined = expQ;
    buildExpected(0, 150, 100, 3, 1, 6);
    foreach (expQ[i]) combined.push_back(expQ[i]);
    issue(0, 3, 4, 2, 2, 1);
    hs1 = hsCyc;
    @(negedge clock);
    cmd_x = 8'd150; cmd_y = 7'd100; cmd_w = 8'd3; cmd_h = 7'd1; cmd_color = 3'd6;
    gotQ.delete();
    for (int i = 0; i < 100; i++) begin
      if (hs2 >= 0) cmd_valid = 1'b0;
      if (plot_valid) gotQ.push_back(pack(plot_x, plot_y, plot_color));
      if (done) begin
        if (done1 < 0) done1 = cycle;
        else begin
          done2 = cycle;
          break;
        end
      end
      if (cmd_ready && cmd_valid) begin
        hs2 = cycle;
        accepts++;
      end
      @(negedge clock);
    end
    cmd_valid = 1'b0;
    expQ = combined;
    total++;
    if (done1 !== hs1 + 6 || hs2 !== done1 + 1 || accepts !== 1) begin
      bad++;
      $display("[TB] FAIL b2b_accept: done1=%0d hs2=%0d accepts=%0d required done1=%0d hs2=%0d accepts=1",
               done1 - hs1, hs2 - hs1, accepts, 6, 7);
    end
    total++;
    if (done2 !== hs2 + 5) begin
      bad++;
      $display("[TB] FAIL b2b_done2: latency actual=%0d required=5", done2 - hs2);
    end
    total++;
    if (firstDiff() !== -1) begin
      bad++;
      $display("[TB] FAIL b2b_stream: diverges at %0d actual size=%0d required size=%0d", firstDiff(), gotQ.size(), expQ.size());
    end
  endtask

  initial begin
    test_reset();
    test_fill_basic();
    test_clip_corner();
    test_reject();
    test_random();
    test_reset_mid();
    test_back_to_back();
    test_clear_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
